// File: rtl/sincronizador_vga_if.sv
// VGA timing bundle from the sync generator to the renderer and the connector.
interface sincronizador_vga_if;
  logic       hsync;
  logic       vsync;
  logic       video_mostrar;
  logic       pixel_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       fin_cuadro;

  modport master (
    output hsync, vsync, video_mostrar, pixel_tick, pixel_x, pixel_y, fin_cuadro
  );

  modport slave (
    input hsync, vsync, video_mostrar, pixel_tick, pixel_x, pixel_y, fin_cuadro
  );
endinterface

// File: rtl/sincronizador_vga.sv
// Free-running VGA 640x480@60 timing generator with pixel enable and end-of-frame pulse.
module sincronizador_vga #(
  parameter int DIV = 2,
  parameter int HD  = 640,
  parameter int HF  = 16,
  parameter int HR  = 96,
  parameter int HB  = 48,
  parameter int VD  = 480,
  parameter int VF  = 10,
  parameter int VR  = 2,
  parameter int VB  = 33
) (
  input  logic                  clk,
  input  logic                  reset,
  sincronizador_vga_if.master   vga
);

  localparam int HT    = HD + HF + HR + HB;
  localparam int VT    = VD + VF + VR + VB;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             tick_q, tick_d;
  logic             fin_q, fin_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             vid_q, vid_d;

  always_comb begin
    div_d  = (div_q == DIV_W'(DIV - 1)) ? '0 : div_q + DIV_W'(1);
    tick_d = (div_q == DIV_W'(DIV - 1));

    x_d = x_q;
    y_d = y_q;
    if (tick_q) begin
      if (x_q == 10'(HT - 1)) begin
        x_d = '0;
        y_d = (y_q == 10'(VT - 1)) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    // Decode from next-state counters so every output lines up with pixel_x/pixel_y.
    hs_d  = !((x_d >= 10'(HD + HF)) && (x_d <= 10'(HD + HF + HR - 1)));
    vs_d  = !((y_d >= 10'(VD + VF)) && (y_d <= 10'(VD + VF + VR - 1)));
    vid_d = (x_d < 10'(HD)) && (y_d < 10'(VD));
    fin_d = tick_d && (x_d == 10'(HT - 1)) && (y_d == 10'(VT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      tick_q <= 1'b0;
      fin_q  <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      vid_q  <= 1'b1;
    end else begin
      div_q  <= div_d;
      x_q    <= x_d;
      y_q    <= y_d;
      tick_q <= tick_d;
      fin_q  <= fin_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      vid_q  <= vid_d;
    end
  end

  assign vga.hsync         = hs_q;
  assign vga.vsync         = vs_q;
  assign vga.video_mostrar = vid_q;
  assign vga.pixel_tick    = tick_q;
  assign vga.pixel_x       = x_q;
  assign vga.pixel_y       = y_q;
  assign vga.fin_cuadro    = fin_q;

endmodule

// File: tb/tb_sincronizador_vga.sv
// Bench for sincronizador_vga: standard, reduced-geometry and DIV=1 instances against a closed-form timing model.
module tb_sincronizador_vga;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       h;
    logic       v;
    logic       vid;
    logic       tick;
    logic       fin;
  } obs_t;

  localparam obs_t RST_V = {10'd0, 10'd0, 5'b11100};

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_std = 1'b1;
  logic rst_sm  = 1'b1;
  logic rst_d1  = 1'b1;

  sincronizador_vga_if if_std ();
  sincronizador_vga_if if_sm ();
  sincronizador_vga_if if_d1 ();

  sincronizador_vga #(.DIV(2)) dut_std (.clk(clk), .reset(rst_std), .vga(if_std));
  sincronizador_vga #(.DIV(2), .HD(8), .HF(2), .HR(3), .HB(3), .VD(5), .VF(1), .VR(2), .VB(2))
    dut_sm (.clk(clk), .reset(rst_sm), .vga(if_sm));
  sincronizador_vga #(.DIV(1)) dut_d1 (.clk(clk), .reset(rst_d1), .vga(if_d1));

  // Clocks elapsed since the last edge that sampled reset high.
  int k_std = 0, k_sm = 0, k_d1 = 0;
  always @(posedge clk) begin
    k_std <= rst_std ? 0 : k_std + 1;
    k_sm  <= rst_sm  ? 0 : k_sm  + 1;
    k_d1  <= rst_d1  ? 0 : k_d1  + 1;
  end

  int checks = 0;
  int failures = 0;

  // Expected outputs after k clocks: ticks land every DIV clocks, the pixel index is ticks-so-far.
  function automatic obs_t model(int k, int div, int hd, int hf, int hr, int hb,
                                 int vd, int vf, int vr, int vb);
    int ht, vt, t, p, x, y;
    obs_t o;
    ht = hd + hf + hr + hb;
    vt = vd + vf + vr + vb;
    t  = (k >= 1) ? (k - 1) / div : 0;
    p  = t % (ht * vt);
    x  = p % ht;
    y  = p / ht;
    o.x    = 10'(x);
    o.y    = 10'(y);
    o.tick = (k >= 1) && (k % div == 0);
    o.h    = !((x >= hd + hf) && (x < hd + hf + hr));
    o.v    = !((y >= vd + vf) && (y < vd + vf + vr));
    o.vid  = (x < hd) && (y < vd);
    o.fin  = o.tick && (x == ht - 1) && (y == vt - 1);
    return o;
  endfunction

  function automatic obs_t m_std(int k); return model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33); endfunction
  function automatic obs_t m_sm(int k);  return model(k, 2, 8, 2, 3, 3, 5, 1, 2, 2);          endfunction
  function automatic obs_t m_d1(int k);  return model(k, 1, 640, 16, 96, 48, 480, 10, 2, 33); endfunction

  function automatic obs_t get_std();
    return {if_std.pixel_x, if_std.pixel_y, if_std.hsync, if_std.vsync,
            if_std.video_mostrar, if_std.pixel_tick, if_std.fin_cuadro};
  endfunction
  function automatic obs_t get_sm();
    return {if_sm.pixel_x, if_sm.pixel_y, if_sm.hsync, if_sm.vsync,
            if_sm.video_mostrar, if_sm.pixel_tick, if_sm.fin_cuadro};
  endfunction
  function automatic obs_t get_d1();
    return {if_d1.pixel_x, if_d1.pixel_y, if_d1.hsync, if_d1.vsync,
            if_d1.video_mostrar, if_d1.pixel_tick, if_d1.fin_cuadro};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t g;
    rst_std = 1'b1; rst_sm = 1'b1; rst_d1 = 1'b1;
    repeat (3) cyc();
    g = get_std(); checks++;
    if (g !== RST_V) begin failures++; $display("FAIL reset_std got=%h required=%h", g, RST_V); end
    g = get_sm(); checks++;
    if (g !== RST_V) begin failures++; $display("FAIL reset_sm got=%h required=%h", g, RST_V); end
    g = get_d1(); checks++;
    if (g !== RST_V) begin failures++; $display("FAIL reset_d1 got=%h required=%h", g, RST_V); end
    rst_std = 1'b0; rst_sm = 1'b0; rst_d1 = 1'b0;
    cyc();
    checks++;
    if (if_std.pixel_tick !== 1'b0) begin failures++; $display("FAIL tick_std_clk1 got=%b required=0", if_std.pixel_tick); end
    checks++;
    if (if_d1.pixel_tick !== 1'b1) begin failures++; $display("FAIL tick_d1_clk1 got=%b required=1", if_d1.pixel_tick); end
    cyc();
    checks++;
    if (if_std.pixel_tick !== 1'b1) begin failures++; $display("FAIL tick_std_clk2 got=%b required=1", if_std.pixel_tick); end
    for (int i = 0; i < 8; i++) begin
      cyc();
      g = get_std(); checks++;
      if (g !== m_std(k_std)) begin failures++; $display("FAIL tick_period k=%0d got=%h required=%h", k_std, g, m_std(k_std)); end
    end
  endtask

  task automatic test_line();
    obs_t g, e;
    int hs_low, vid_fall;
    logic prev_vid;
    hs_low = 0; vid_fall = -1; prev_vid = 1'b1;
    for (int i = 0; i < 3300; i++) begin
      cyc();
      g = get_std(); e = m_std(k_std); checks++;
      if (g !== e) begin failures++; $display("FAIL line k=%0d got=%h required=%h", k_std, g, e); end
      if (g.y == 10'd0 && !g.h) hs_low++;
      if (prev_vid && !g.vid && vid_fall < 0) vid_fall = int'(g.x);
      prev_vid = g.vid;
    end
    checks++;
    if (hs_low != 192) begin failures++; $display("FAIL hsync_low_clks got=%0d required=192", hs_low); end
    checks++;
    if (vid_fall != 640) begin failures++; $display("FAIL video_fall_x got=%0d required=640", vid_fall); end
  endtask

  task automatic test_frame();
    obs_t g, e;
    int n, fins, last_fin, vs_low;
    rst_sm = 1'b1; cyc(); rst_sm = 1'b0;
    n = 640 + int'($urandom_range(0, 300));
    fins = 0; last_fin = -1; vs_low = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      g = get_sm(); e = m_sm(k_sm); checks++;
      if (g !== e) begin failures++; $display("FAIL frame k=%0d got=%h required=%h", k_sm, g, e); end
      if (!g.v && k_sm <= 320) vs_low++;
      if (g.fin) begin
        checks++;
        if (g.x != 10'd15 || g.y != 10'd9 || !g.tick) begin
          failures++; $display("FAIL fin_position got x=%0d y=%0d tick=%b required x=15 y=9 tick=1", g.x, g.y, g.tick);
        end
        if (last_fin >= 0) begin
          checks++;
          if (k_sm - last_fin != 320) begin failures++; $display("FAIL frame_len got=%0d required=320", k_sm - last_fin); end
        end
        last_fin = k_sm;
        fins++;
      end
    end
    checks++;
    if (fins != n / 320) begin failures++; $display("FAIL fin_count got=%0d required=%0d", fins, n / 320); end
    checks++;
    if (vs_low != 64) begin failures++; $display("FAIL vsync_low_clks got=%0d required=64", vs_low); end
  endtask

  task automatic test_reset_mid();
    obs_t g, e;
    bit found;
    int tx, ty;
    rst_std = 1'b1; cyc(); rst_std = 1'b0;
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      cyc();
      if (if_std.pixel_x == 10'd700 && if_std.pixel_y == 10'd1) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL reach_700_1 timeout got=%0d,%0d", if_std.pixel_x, if_std.pixel_y); end
    checks++;
    if (if_std.hsync !== 1'b0) begin failures++; $display("FAIL hsync_at_700 got=%b required=0", if_std.hsync); end
    rst_std = 1'b1; cyc();
    g = get_std(); checks++;
    if (g !== RST_V) begin failures++; $display("FAIL midreset_std got=%h required=%h", g, RST_V); end
    rst_std = 1'b0;
    for (int i = 0; i < 1700; i++) begin
      cyc();
      g = get_std(); e = m_std(k_std); checks++;
      if (g !== e) begin failures++; $display("FAIL restart_std k=%0d got=%h required=%h", k_std, g, e); end
    end
    tx = 10 + int'($urandom_range(0, 2));
    ty = int'($urandom_range(1, 9));
    rst_sm = 1'b1; cyc(); rst_sm = 1'b0;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      cyc();
      if (int'(if_sm.pixel_x) == tx && int'(if_sm.pixel_y) == ty) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL reach_sm timeout got=%0d,%0d required=%0d,%0d", if_sm.pixel_x, if_sm.pixel_y, tx, ty); end
    rst_sm = 1'b1; cyc();
    g = get_sm(); checks++;
    if (g !== RST_V) begin failures++; $display("FAIL midreset_sm got=%h required=%h", g, RST_V); end
    rst_sm = 1'b0;
  endtask

  task automatic test_div1();
    obs_t g, e;
    int n, last_wrap, wraps;
    logic [9:0] prev_x;
    rst_d1 = 1'b1; cyc(); rst_d1 = 1'b0;
    n = 1700 + int'($urandom_range(0, 200));
    last_wrap = -1; wraps = 0; prev_x = '0;
    for (int i = 0; i < n; i++) begin
      cyc();
      g = get_d1(); e = m_d1(k_d1); checks++;
      if (g !== e) begin failures++; $display("FAIL div1 k=%0d got=%h required=%h", k_d1, g, e); end
      if (g.x == 10'd0 && prev_x == 10'd799) begin
        if (last_wrap >= 0) begin
          checks++;
          if (k_d1 - last_wrap != 800) begin failures++; $display("FAIL div1_line got=%0d required=800", k_d1 - last_wrap); end
        end
        last_wrap = k_d1;
        wraps++;
      end
      prev_x = g.x;
    end
    checks++;
    if (wraps < 2) begin failures++; $display("FAIL div1_wraps got=%0d required>=2", wraps); end
  endtask

  task automatic test_back_to_back();
    obs_t g, e;
    int n, r;
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 400));
      for (int i = 0; i < n; i++) begin
        cyc();
        g = get_sm(); e = m_sm(k_sm); checks++;
        if (g !== e) begin failures++; $display("FAIL b2b_run k=%0d got=%h required=%h", k_sm, g, e); end
      end
      rst_sm = 1'b1;
      r = int'($urandom_range(1, 2));
      for (int i = 0; i < r; i++) begin
        cyc();
        g = get_sm(); checks++;
        if (g !== RST_V) begin failures++; $display("FAIL b2b_reset got=%h required=%h", g, RST_V); end
      end
      rst_sm = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_reset_mid();
    test_div1();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
